if_id_skid: RTL and testbench



---
 rtl/if_id_skid.sv | 147 ++++++++++++++
 tb/tb_if_id_skid.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/if_id_skid.sv
// IF->ID pipeline register with a two-entry skid buffer.
// The main entry drives id_pc/id_inst; the skid entry catches the one
// instruction that can arrive while ID stalls, so if_ready can come straight
// from a flop and never depends on the same-cycle id_ready.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both 1. A producer holding valid=1 keeps its payload stable until it
// transfers. ready may be raised without waiting for valid.
// IF side: if_ready is registered. ID side: id_valid/id_pc/id_inst stay
// stable while id_valid=1 and id_ready=0.
module if_id_skid #(
  parameter int ADDR_WIDTH = 32,
  parameter int INST_WIDTH = 32,
  parameter logic [INST_WIDTH-1:0] NOP_INST = '0,
  parameter int CNT_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  if_valid,
  output logic                  if_ready,
  input  logic [ADDR_WIDTH-1:0] if_pc,
  input  logic [INST_WIDTH-1:0] if_inst,
  output logic                  id_valid,
  input  logic                  id_ready,
  output logic [ADDR_WIDTH-1:0] id_pc,
  output logic [INST_WIDTH-1:0] id_inst,
  output logic [1:0]            occupancy,
  output logic [CNT_WIDTH-1:0]  stall_cnt
);

  // The state encoding equals the number of held entries.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t                state, state_n;
  logic [ADDR_WIDTH-1:0] main_pc, main_pc_n;
  logic [INST_WIDTH-1:0] main_inst, main_inst_n;
  logic [ADDR_WIDTH-1:0] skid_pc, skid_pc_n;
  logic [INST_WIDTH-1:0] skid_inst, skid_inst_n;
  logic                  if_ready_q;
  logic                  in_xfer, out_xfer;

  assign id_valid  = (state != EMPTY);
  assign id_pc     = main_pc;
  assign id_inst   = main_inst;
  assign occupancy = state;
  assign if_ready  = if_ready_q;

  assign in_xfer  = if_valid & if_ready_q;
  assign out_xfer = id_valid & id_ready;

  // State, entry registers and the registered if_ready (taken from next state).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= EMPTY;
      main_pc    <= '0;
      main_inst  <= NOP_INST;
      skid_pc    <= '0;
      skid_inst  <= '0;
      if_ready_q <= 1'b1;
    end else begin
      state      <= state_n;
      main_pc    <= main_pc_n;
      main_inst  <= main_inst_n;
      skid_pc    <= skid_pc_n;
      skid_inst  <= skid_inst_n;
      if_ready_q <= (state_n != FULL);
    end
  end

  // Next-state and entry movement; flush overrides every transfer.
  always_comb begin
    state_n     = state;
    main_pc_n   = main_pc;
    main_inst_n = main_inst;
    skid_pc_n   = skid_pc;
    skid_inst_n = skid_inst;
    if (flush) begin
      // Incoming instruction in this cycle is dropped along with held ones.
      state_n     = EMPTY;
      main_pc_n   = '0;
      main_inst_n = NOP_INST;
      skid_pc_n   = '0;
      skid_inst_n = '0;
    end else begin
      case (state)
        EMPTY: begin
          if (in_xfer) begin
            main_pc_n   = if_pc;
            main_inst_n = if_inst;
            state_n     = ONE;
          end
        end
        ONE: begin
          case ({in_xfer, out_xfer})
            2'b11: begin
              main_pc_n   = if_pc;
              main_inst_n = if_inst;
            end
            2'b10: begin
              skid_pc_n   = if_pc;
              skid_inst_n = if_inst;
              state_n     = FULL;
            end
            2'b01: begin
              // id_pc keeps its last value; only the instruction goes to NOP.
              main_inst_n = NOP_INST;
              state_n     = EMPTY;
            end
            default: ;
          endcase
        end
        FULL: begin
          // if_ready is 0 here, so only the ID side can move.
          if (out_xfer) begin
            main_pc_n   = skid_pc;
            main_inst_n = skid_inst;
            skid_pc_n   = '0;
            skid_inst_n = '0;
            state_n     = ONE;
          end
        end
        default: state_n = EMPTY;
      endcase
    end
  end

  // Saturating count of cycles where ID holds off a live instruction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (id_valid && !id_ready && !flush && (stall_cnt != {CNT_WIDTH{1'b1}})) begin
      stall_cnt <= stall_cnt + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    end
  end

`ifndef SYNTHESIS
  // An accepted instruction while both entries are held would be lost.
  a_no_accept_when_full: assert property (@(posedge clk) disable iff (rst)
    !(if_valid && if_ready && (state == FULL)));
`endif

endmodule

// File: tb/tb_if_id_skid.sv
// Bench for if_id_skid: directed scenarios with hand-computed constants plus
// a negedge monitor that keeps an expected queue of accepted instructions.
module tb_if_id_skid;

  localparam int AW = 32;
  localparam int IW = 32;
  localparam int CW = 4;
  localparam logic [IW-1:0] NOP = 32'h0000_0013;

  logic          clk;
  logic          rst;
  logic          flush;
  logic          if_valid;
  logic          if_ready;
  logic [AW-1:0] if_pc;
  logic [IW-1:0] if_inst;
  logic          id_valid;
  logic          id_ready;
  logic [AW-1:0] id_pc;
  logic [IW-1:0] id_inst;
  logic [1:0]    occupancy;
  logic [CW-1:0] stall_cnt;

  int vectors = 0;
  int miscompares = 0;

  // Expected queue: {pc, inst} of every instruction the model accepted.
  logic [AW+IW-1:0] exp_q[$];
  logic [AW-1:0]    m_idpc;
  logic [CW-1:0]    m_stall;

  if_id_skid #(
    .ADDR_WIDTH(AW),
    .INST_WIDTH(IW),
    .NOP_INST(NOP),
    .CNT_WIDTH(CW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .flush(flush),
    .if_valid(if_valid),
    .if_ready(if_ready),
    .if_pc(if_pc),
    .if_inst(if_inst),
    .id_valid(id_valid),
    .id_ready(id_ready),
    .id_pc(id_pc),
    .id_inst(id_inst),
    .occupancy(occupancy),
    .stall_cnt(stall_cnt)
  );

  // Clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic present(input logic [AW-1:0] pc);
    if_valid = 1'b1;
    if_pc    = pc;
    if_inst  = {pc[15:0], 16'hC0DE};
  endtask

  // Monitor / scoreboard: compare at negedge, then advance the model for the
  // coming rising edge (inputs are stable between negedge and posedge).
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      m_idpc  = '0;
      m_stall = '0;
    end else begin
      chk("m_if_ready", {31'b0, if_ready}, {31'b0, exp_q.size() != 2});
      chk("m_id_valid", {31'b0, id_valid}, {31'b0, exp_q.size() != 0});
      chk("m_occupancy", {30'b0, occupancy}, 32'(exp_q.size()));
      chk("m_stall_cnt", {28'b0, stall_cnt}, {28'b0, m_stall});
      if (exp_q.size() != 0) begin
        m_idpc = exp_q[0][AW+IW-1:IW];
        chk("m_id_pc", id_pc, exp_q[0][AW+IW-1:IW]);
        chk("m_id_inst", id_inst, exp_q[0][IW-1:0]);
      end else begin
        chk("m_id_pc_idle", id_pc, m_idpc);
        chk("m_id_inst_nop", id_inst, NOP);
      end
      if (exp_q.size() != 0 && !id_ready && !flush && m_stall != 4'hF) m_stall++;
      if (flush) begin
        exp_q.delete();
        m_idpc = '0;
      end else begin
        logic take_in;
        take_in = if_valid && (exp_q.size() != 2);
        if (exp_q.size() != 0 && id_ready) void'(exp_q.pop_front());
        if (take_in) exp_q.push_back({if_pc, if_inst});
      end
    end
  end

  // Driver: directed scenarios, then a randomised valid/ready run.
  initial begin
    rst = 1'b1; flush = 1'b0; if_valid = 1'b0; id_ready = 1'b0;
    if_pc = '0; if_inst = '0;
    #2;
    chk("rst_id_valid", {31'b0, id_valid}, 32'h0);
    chk("rst_if_ready", {31'b0, if_ready}, 32'h1);
    chk("rst_id_inst", id_inst, NOP);
    chk("rst_id_pc", id_pc, 32'h0);
    step();
    step();
    rst = 1'b0;

    // Streaming: one instruction per cycle, never more than one held.
    id_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      present(32'(i * 4));
      step();
      chk("stream_pc", id_pc, 32'(i * 4));
      chk("stream_occ", {30'b0, occupancy}, 32'h1);
      chk("stream_rdy", {31'b0, if_ready}, 32'h1);
    end
    if_valid = 1'b0;
    step();
    chk("stream_drain_inst", id_inst, NOP);
    chk("stream_stall", {28'b0, stall_cnt}, 32'h0);

    // Back-pressure: fill both entries, hold, then drain in order.
    id_ready = 1'b0;
    present(32'h10);
    step();
    present(32'h14);
    step();
    if_valid = 1'b0;
    chk("bp_occ2", {30'b0, occupancy}, 32'h2);
    chk("bp_rdy0", {31'b0, if_ready}, 32'h0);
    step();
    step();
    chk("bp_hold_pc", id_pc, 32'h10);
    chk("bp_stall", {28'b0, stall_cnt}, 32'h3);
    id_ready = 1'b1;
    step();
    chk("bp_pc2", id_pc, 32'h14);
    chk("bp_occ1", {30'b0, occupancy}, 32'h1);
    step();
    chk("bp_occ0", {30'b0, occupancy}, 32'h0);
    chk("bp_nop", id_inst, NOP);
    chk("bp_pc_held", id_pc, 32'h14);

    // Flush while FULL, with a new instruction offered in the flush cycle.
    id_ready = 1'b0;
    present(32'h20);
    step();
    present(32'h24);
    step();
    present(32'h28);
    flush = 1'b1;
    step();
    flush = 1'b0;
    if_valid = 1'b0;
    chk("fl_valid", {31'b0, id_valid}, 32'h0);
    chk("fl_pc", id_pc, 32'h0);
    chk("fl_inst", id_inst, NOP);
    chk("fl_occ", {30'b0, occupancy}, 32'h0);
    chk("fl_rdy", {31'b0, if_ready}, 32'h1);
    chk("fl_stall", {28'b0, stall_cnt}, 32'h4);
    // Flush in ONE while if_ready=1: the offered instruction is dropped too.
    present(32'h30);
    step();
    present(32'h34);
    flush = 1'b1;
    step();
    flush = 1'b0;
    if_valid = 1'b0;
    id_ready = 1'b1;
    chk("fl1_occ", {30'b0, occupancy}, 32'h0);
    step();
    chk("fl1_valid", {31'b0, id_valid}, 32'h0);

    // Asynchronous reset while stalled and full.
    id_ready = 1'b0;
    present(32'h38);
    step();
    present(32'h3C);
    step();
    if_valid = 1'b0;
    chk("ar_occ2", {30'b0, occupancy}, 32'h2);
    chk("ar_stall5", {28'b0, stall_cnt}, 32'h5);
    #2 rst = 1'b1;
    #1;
    chk("ar_valid", {31'b0, id_valid}, 32'h0);
    chk("ar_occ", {30'b0, occupancy}, 32'h0);
    chk("ar_rdy", {31'b0, if_ready}, 32'h1);
    chk("ar_stall", {28'b0, stall_cnt}, 32'h0);
    chk("ar_pc", id_pc, 32'h0);
    chk("ar_inst", id_inst, NOP);
    step();
    rst = 1'b0;
    id_ready = 1'b1;
    present(32'h40);
    step();
    if_valid = 1'b0;
    chk("ar_first_pc", id_pc, 32'h40);
    chk("ar_first_valid", {31'b0, id_valid}, 32'h1);

    // Saturation of the 4-bit stall counter.
    step();
    id_ready = 1'b0;
    present(32'h50);
    step();
    if_valid = 1'b0;
    repeat (20) step();
    chk("sat_15", {28'b0, stall_cnt}, 32'hF);
    repeat (3) step();
    chk("sat_hold", {28'b0, stall_cnt}, 32'hF);
    id_ready = 1'b1;
    step();

    // Randomised valid/ready with occasional flushes.
    for (int c = 0; c < 3000; c++) begin
      if_valid = ($urandom_range(0, 2) != 0);
      if_pc    = $urandom;
      if_inst  = $urandom;
      id_ready = ($urandom_range(0, 2) != 0);
      flush    = ($urandom_range(0, 40) == 0);
      step();
    end
    flush = 1'b0;
    if_valid = 1'b0;
    id_ready = 1'b1;
    repeat (4) step();
    chk("end_occ", {30'b0, occupancy}, 32'h0);
    chk("end_valid", {31'b0, id_valid}, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
